// File: rtl/rf_phoenix_trace_buffer_pkg.sv
// rfPhoenixPkg: shared types and constants for the phoenix instruction-trace buffer.
//   Address     : branch-target address type
//   ASID        : address-space identifier type
//   trace_ptr_t : 11-bit occupancy type (0..1024)
package rfPhoenixPkg;

    localparam int unsigned TRACE_DEPTH = 1024;
    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned ASID_W      = 8;

    typedef logic [ADDR_W-1:0] Address;
    typedef logic [ASID_W-1:0] ASID;
    typedef logic [10:0]       trace_ptr_t;

endpackage

// File: rtl/rf_phoenix_trace_buffer_if.sv
// Trace-buffer signal bundle: capture controls, commit-stage branch events and the
// ALU-facing pop interface.
//   master : the environment driving commits and reads (core / ALU side)
//   slave  : the trace buffer itself
interface rf_phoenix_trace_buffer_if;
    import rfPhoenixPkg::*;

    logic       trace_en;
    logic       trace_clr;
    logic       ovr_mode;
    logic       dedup_en;
    logic       asid_filt_en;
    ASID        filt_asid;
    logic       cmt_valid;
    logic       cmt_taken;
    ASID        cmt_asid;
    Address     cmt_tgt;
    logic       trace_rd;
    Address     trace_dout;
    logic       trace_valid;
    logic       trace_empty;
    trace_ptr_t trace_count;
    logic       trace_ovf;

    modport master (
        output trace_en, trace_clr, ovr_mode, dedup_en, asid_filt_en, filt_asid,
               cmt_valid, cmt_taken, cmt_asid, cmt_tgt, trace_rd,
        input  trace_dout, trace_valid, trace_empty, trace_count, trace_ovf
    );

    modport slave (
        input  trace_en, trace_clr, ovr_mode, dedup_en, asid_filt_en, filt_asid,
               cmt_valid, cmt_taken, cmt_asid, cmt_tgt, trace_rd,
        output trace_dout, trace_valid, trace_empty, trace_count, trace_ovf
    );

endinterface

// File: rtl/rf_phoenix_trace_buffer_trace_ram.sv
// trace_ram: simple dual-port storage for the trace FIFO.
//   clk, rst_n : clock, async active-low reset (read register only)
//   wr_en/wr_addr/wr_data : synchronous write port
//   rd_en/rd_addr/rd_data : registered synchronous read port; rd_data holds between reads
// Read-during-write to the same address returns the old contents.
module trace_ram
    import rfPhoenixPkg::*;
#(
    parameter int unsigned DEPTH = TRACE_DEPTH,
    parameter int unsigned AWID  = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AWID-1:0] wr_addr,
    input  Address          wr_data,
    input  logic            rd_en,
    input  logic [AWID-1:0] rd_addr,
    output Address          rd_data
);

    Address mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/rf_phoenix_trace_buffer.sv
// rf_phoenix_trace_buffer: captures qualified taken-branch targets into a FIFO that
// the vector ALU pops one entry per trace_rd.
//   clk, rst_n : clock, async active-low reset
//   trc        : rf_phoenix_trace_buffer_if.slave (controls, commit events, pop port, status)
// Pointers carry one extra bit so full (count==DEPTH) and empty (count==0) differ.
module rf_phoenix_trace_buffer
    import rfPhoenixPkg::*;
#(
    parameter int unsigned DEPTH = TRACE_DEPTH,
    parameter int unsigned AWID  = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    rf_phoenix_trace_buffer_if.slave     trc
);

    typedef logic [AWID:0] ptr_t;

    ptr_t       wptr;
    ptr_t       rptr;
    trace_ptr_t count;
    Address     last_addr;
    logic       last_vld;
    logic       ovf;
    logic       valid;
    Address     ram_q;

    logic full;
    logic empty;
    logic asid_ok;
    logic dup;
    logic wr_req;
    logic rd_ok;
    logic drop;
    logic overwrite;
    logic wr_ok;
    logic rptr_inc;

    assign count = trace_ptr_t'(wptr - rptr);
    assign full  = (count == trace_ptr_t'(DEPTH));
    assign empty = (count == '0);

    // A read in the same cycle as a full-buffer write frees the slot, so the write
    // is treated as a normal not-full write: no drop, no overwrite, no overflow.
    always_comb begin
        asid_ok   = !trc.asid_filt_en || (trc.cmt_asid == trc.filt_asid);
        dup       = trc.dedup_en && last_vld && (trc.cmt_tgt == last_addr);
        wr_req    = trc.trace_en && trc.cmt_valid && trc.cmt_taken && asid_ok && !dup
                    && !trc.trace_clr;
        rd_ok     = trc.trace_rd && !empty && !trc.trace_clr;
        drop      = wr_req && full && !rd_ok && !trc.ovr_mode;
        overwrite = wr_req && full && !rd_ok && trc.ovr_mode;
        wr_ok     = wr_req && !drop;
        rptr_inc  = rd_ok || overwrite;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            ovf       <= 1'b0;
            last_vld  <= 1'b0;
            last_addr <= '0;
            valid     <= 1'b0;
        end else if (trc.trace_clr) begin
            wptr     <= '0;
            rptr     <= '0;
            ovf      <= 1'b0;
            last_vld <= 1'b0;
            valid    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr      <= wptr + 1'b1;
                last_addr <= trc.cmt_tgt;
                last_vld  <= 1'b1;
            end
            if (rptr_inc) begin
                rptr <= rptr + 1'b1;
            end
            if (drop || overwrite) begin
                ovf <= 1'b1;
            end
            valid <= rd_ok;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .AWID  (AWID)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_ok),
        .wr_addr (wptr[AWID-1:0]),
        .wr_data (trc.cmt_tgt),
        .rd_en   (rd_ok),
        .rd_addr (rptr[AWID-1:0]),
        .rd_data (ram_q)
    );

    assign trc.trace_dout  = ram_q;
    assign trc.trace_valid = valid;
    assign trc.trace_empty = empty;
    assign trc.trace_count = count;
    assign trc.trace_ovf   = ovf;

endmodule

// File: tb/tb_rf_phoenix_trace_buffer.sv
// Testbench for rf_phoenix_trace_buffer: directed scenarios plus randomized traffic,
// compared each cycle against a queue-based model of the trace FIFO.
module tb_rf_phoenix_trace_buffer;
    import rfPhoenixPkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_phoenix_trace_buffer_if tif ();

    rf_phoenix_trace_buffer #(
        .DEPTH (TRACE_DEPTH),
        .AWID  (10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .trc   (tif)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    Address q[$];
    bit     m_ovf   = 1'b0;
    bit     m_lvld  = 1'b0;
    Address m_last  = '0;
    Address m_dout  = '0;
    bit     m_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_lvld  = 1'b0;
        m_last  = '0;
        m_dout  = '0;
        m_valid = 1'b0;
    endtask

    // One clock edge of FIFO behaviour: flush wins; otherwise pop the oldest (if any),
    // then append the qualified target, evicting the oldest or dropping when full.
    task automatic model_edge();
        bit qual;
        bit popped;
        if (tif.trace_clr) begin
            q.delete();
            m_ovf   = 1'b0;
            m_lvld  = 1'b0;
            m_valid = 1'b0;
            return;
        end
        qual = tif.trace_en && tif.cmt_valid && tif.cmt_taken
               && (!tif.asid_filt_en || tif.cmt_asid == tif.filt_asid)
               && !(tif.dedup_en && m_lvld && tif.cmt_tgt == m_last);
        popped = tif.trace_rd && q.size() != 0;
        if (popped) m_dout = q.pop_front();
        m_valid = popped;
        if (qual) begin
            if (q.size() < int'(TRACE_DEPTH)) begin
                q.push_back(tif.cmt_tgt);
                m_last = tif.cmt_tgt;
                m_lvld = 1'b1;
            end else if (tif.ovr_mode) begin
                void'(q.pop_front());
                q.push_back(tif.cmt_tgt);
                m_last = tif.cmt_tgt;
                m_lvld = 1'b1;
                m_ovf  = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".count"}, 32'(tif.trace_count), 32'(q.size()));
        chk({tag, ".empty"}, 32'(tif.trace_empty), 32'(q.size() == 0));
        chk({tag, ".ovf"},   32'(tif.trace_ovf),   32'(m_ovf));
        chk({tag, ".valid"}, 32'(tif.trace_valid), 32'(m_valid));
        chk({tag, ".dout"},  tif.trace_dout,       m_dout);
    endtask

    // Inputs are changed only right after a negedge; the model steps at the posedge
    // and the DUT is sampled at the following negedge.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        tif.cmt_valid = 1'b0;
        tif.cmt_taken = 1'b0;
        tif.trace_rd  = 1'b0;
        tif.trace_clr = 1'b0;
    endtask

    task automatic commit(input string tag, input Address tgt, input ASID asid, input bit rd);
        tif.cmt_valid = 1'b1;
        tif.cmt_taken = 1'b1;
        tif.cmt_tgt   = tgt;
        tif.cmt_asid  = asid;
        tif.trace_rd  = rd;
        step(tag);
        idle_inputs();
    endtask

    task automatic pop(input string tag);
        tif.trace_rd = 1'b1;
        step(tag);
        idle_inputs();
    endtask

    task automatic flush();
        tif.trace_clr = 1'b1;
        step("clr");
        idle_inputs();
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < int'(TRACE_DEPTH); i++) commit("fill", Address'(i), '0, 1'b0);
    endtask

    initial begin
        tif.trace_en     = 1'b0;
        tif.ovr_mode     = 1'b0;
        tif.dedup_en     = 1'b0;
        tif.asid_filt_en = 1'b0;
        tif.filt_asid    = '0;
        tif.cmt_asid     = '0;
        tif.cmt_tgt      = '0;
        idle_inputs();
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
        tif.trace_en = 1'b1;

        // Three writes then three reads
        commit("w100", 32'h100, '0, 1'b0);
        commit("w200", 32'h200, '0, 1'b0);
        commit("w300", 32'h300, '0, 1'b0);
        chk("basic.count3", 32'(tif.trace_count), 32'd3);
        pop("r1"); chk("basic.rd1", tif.trace_dout, 32'h100); chk("basic.v1", 32'(tif.trace_valid), 32'd1);
        pop("r2"); chk("basic.rd2", tif.trace_dout, 32'h200);
        pop("r3"); chk("basic.rd3", tif.trace_dout, 32'h300);
        step("hold");
        chk("basic.empty", 32'(tif.trace_empty), 32'd1);
        chk("basic.vdrop", 32'(tif.trace_valid), 32'd0);

        // Read while empty is ignored
        pop("rd_empty");
        chk("rdempty.valid", 32'(tif.trace_valid), 32'd0);
        chk("rdempty.count", 32'(tif.trace_count), 32'd0);
        commit("rdempty.w", 32'h5A5, '0, 1'b0);
        pop("rdempty.r");
        chk("rdempty.rptr", tif.trace_dout, 32'h5A5);

        // Full, drop policy
        flush();
        tif.ovr_mode = 1'b0;
        fill_ramp();
        commit("wdead", 32'hDEAD, '0, 1'b0);
        chk("drop.count", 32'(tif.trace_count), 32'd1024);
        chk("drop.ovf", 32'(tif.trace_ovf), 32'd1);
        pop("drop.pop");
        chk("drop.first", tif.trace_dout, 32'h0);

        // Full, overwrite policy
        flush();
        tif.ovr_mode = 1'b1;
        fill_ramp();
        commit("wbeef", 32'hBEEF, '0, 1'b0);
        chk("ovw.count", 32'(tif.trace_count), 32'd1024);
        chk("ovw.ovf", 32'(tif.trace_ovf), 32'd1);
        for (int i = 0; i < int'(TRACE_DEPTH); i++) begin
            pop("ovw.pop");
            if (i == 0)    chk("ovw.first", tif.trace_dout, 32'h1);
            if (i == 1023) chk("ovw.last", tif.trace_dout, 32'hBEEF);
        end

        // Full with simultaneous read and write, both policies
        flush();
        tif.ovr_mode = 1'b0;
        fill_ramp();
        commit("fullrw0", 32'h777, '0, 1'b1);
        chk("fullrw0.dout", tif.trace_dout, 32'h0);
        chk("fullrw0.count", 32'(tif.trace_count), 32'd1024);
        chk("fullrw0.ovf", 32'(tif.trace_ovf), 32'd0);
        tif.ovr_mode = 1'b1;
        commit("fullrw1", 32'h888, '0, 1'b1);
        chk("fullrw1.dout", tif.trace_dout, 32'h1);
        chk("fullrw1.count", 32'(tif.trace_count), 32'd1024);
        chk("fullrw1.ovf", 32'(tif.trace_ovf), 32'd0);

        // Dedup and ASID filter
        flush();
        tif.ovr_mode = 1'b0;
        tif.dedup_en = 1'b1;
        repeat (3) commit("dd40", 32'h40, '0, 1'b0);
        commit("dd44", 32'h44, '0, 1'b0);
        chk("dedup.count", 32'(tif.trace_count), 32'd2);
        tif.asid_filt_en = 1'b1;
        tif.filt_asid    = 8'd5;
        commit("asid3", 32'h80, 8'd3, 1'b0);
        chk("asid3.count", 32'(tif.trace_count), 32'd2);
        commit("asid5", 32'h84, 8'd5, 1'b0);
        chk("asid5.count", 32'(tif.trace_count), 32'd3);
        tif.asid_filt_en = 1'b0;
        tif.dedup_en     = 1'b0;

        // Read and write while empty; clear together with a write
        flush();
        commit("rw_empty", 32'h55, '0, 1'b1);
        chk("rwempty.count", 32'(tif.trace_count), 32'd1);
        chk("rwempty.valid", 32'(tif.trace_valid), 32'd0);
        tif.trace_clr = 1'b1;
        commit("clr_w", 32'h66, '0, 1'b0);
        chk("clrw.count", 32'(tif.trace_count), 32'd0);

        // Randomized traffic in phases with random mode settings
        for (int ph = 0; ph < 6; ph++) begin
            tif.ovr_mode     = $urandom_range(0, 1);
            tif.dedup_en     = $urandom_range(0, 1);
            tif.asid_filt_en = $urandom_range(0, 1);
            tif.filt_asid    = ASID'($urandom_range(0, 3));
            for (int c = 0; c < 500; c++) begin
                tif.trace_en  = ($urandom_range(0, 9) != 0);
                tif.cmt_valid = $urandom_range(0, 1);
                tif.cmt_taken = ($urandom_range(0, 3) != 0);
                tif.cmt_asid  = ASID'($urandom_range(0, 3));
                tif.cmt_tgt   = Address'($urandom_range(0, 7)) << 2;
                tif.trace_rd  = ($urandom_range(0, 2) == 0);
                tif.trace_clr = ($urandom_range(0, 199) == 0);
                step("rand");
            end
            idle_inputs();
        end

        // Reset asserted mid-burst
        tif.trace_en     = 1'b1;
        tif.ovr_mode     = 1'b0;
        tif.dedup_en     = 1'b0;
        tif.asid_filt_en = 1'b0;
        for (int i = 0; i < 5; i++) commit("preburst", Address'(32'h1000 + i), '0, 1'b0);
        tif.cmt_valid = 1'b1;
        tif.cmt_taken = 1'b1;
        tif.cmt_tgt   = 32'h2000;
        tif.trace_rd  = 1'b1;
        @(posedge clk);
        model_edge();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.count", 32'(tif.trace_count), 32'd0);
        chk("rst.empty", 32'(tif.trace_empty), 32'd1);
        chk("rst.valid", 32'(tif.trace_valid), 32'd0);
        chk("rst.dout",  tif.trace_dout, 32'h0);
        chk("rst.ovf",   32'(tif.trace_ovf), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        commit("post_rst", 32'h3000, '0, 1'b0);
        pop("post_rst.r");
        chk("postrst.dout", tif.trace_dout, 32'h3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
